// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: load-use and multi-cycle stalls, branch flush, forwarding
// Perf counters saturate at all-ones; all control outputs are combinational from state and inputs.
module hazard_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter int MC_LAT       = 4,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_IFID,
  input  logic [REG_AW-1:0] rs2_IFID,
  input  logic [REG_AW-1:0] rs1_IDEX,
  input  logic [REG_AW-1:0] rs2_IDEX,
  input  logic [REG_AW-1:0] rd_IDEX,
  input  logic              memRead_IDEX,
  input  logic              mc_op_IDEX,
  input  logic [REG_AW-1:0] rd_EXMEM,
  input  logic              RegWrite_EXMEM,
  input  logic [REG_AW-1:0] rd_MEMWB,
  input  logic              RegWrite_MEMWB,
  input  logic              branch_taken,
  output logic              PCWrite,
  output logic              Write_IFID,
  output logic              control_mux_sel,
  output logic              hold_IDEX,
  output logic              bubble_EXMEM,
  output logic              flush_IFID,
  output logic              flush_IDEX,
  output logic              flush_EXMEM,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MC_CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_LAT - 2);
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [MC_CW-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use_hit;
  logic             mc_stall;

  assign load_use_hit = memRead_IDEX && (rd_IDEX != '0) &&
                        ((rd_IDEX == rs1_IFID) || (rd_IDEX == rs2_IFID));

  always_comb begin
    state_d         = state_q;
    mc_cnt_d        = mc_cnt_q;
    mc_stall        = 1'b0;
    PCWrite         = 1'b1;
    Write_IFID      = 1'b1;
    control_mux_sel = 1'b0;
    hold_IDEX       = 1'b0;
    bubble_EXMEM    = 1'b0;
    flush_IFID      = 1'b0;
    flush_IDEX      = 1'b0;
    flush_EXMEM     = 1'b0;
    if (rst) begin
      state_d  = ST_RUN;
      mc_cnt_d = '0;
    end else if (branch_taken) begin
      // A taken branch aborts any in-flight multi-cycle op.
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      flush_EXMEM = (FLUSH_STAGES == 3);
      state_d     = ST_RUN;
      mc_cnt_d    = '0;
    end else if (state_q == ST_RUN) begin
      if (mc_op_IDEX) begin
        mc_stall = 1'b1;
        mc_cnt_d = MC_LOAD;
        state_d  = ST_MC_BUSY;
      end else if (load_use_hit) begin
        PCWrite         = 1'b0;
        Write_IFID      = 1'b0;
        control_mux_sel = 1'b1;
      end
    end else if (mc_cnt_q != '0) begin
      mc_stall = 1'b1;
      mc_cnt_d = mc_cnt_q - MC_CW'(1);
    end else begin
      // Last EX cycle of the op: mc_op_IDEX still refers to it, so it is not re-armed.
      state_d = ST_RUN;
    end
    if (mc_stall) begin
      PCWrite      = 1'b0;
      Write_IFID   = 1'b0;
      hold_IDEX    = 1'b1;
      bubble_EXMEM = 1'b1;
    end
  end

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (!rst) begin
      if (RegWrite_EXMEM && (rd_EXMEM != '0) && (rd_EXMEM == rs1_IDEX))
        ForwardA = 2'b10;
      else if (RegWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs1_IDEX))
        ForwardA = 2'b01;
      if (RegWrite_EXMEM && (rd_EXMEM != '0) && (rd_EXMEM == rs2_IDEX))
        ForwardB = 2'b10;
      else if (RegWrite_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs2_IDEX))
        ForwardB = 2'b01;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst && !PCWrite && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!rst && branch_taken && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mc_busy   = !rst && (state_q == ST_MC_BUSY);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed bench for hazard_ctrl_unit
// u_dut: default parameters; u_dut2: MC_LAT=2, FLUSH_STAGES=3, CNT_W=4 on the same inputs.
module tb_hazard_ctrl_unit;
  logic       clk, rst;
  logic [4:0] rs1_IFID, rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX, rd_EXMEM, rd_MEMWB;
  logic       memRead_IDEX, mc_op_IDEX, RegWrite_EXMEM, RegWrite_MEMWB, branch_taken;

  logic        PCWrite, Write_IFID, control_mux_sel, hold_IDEX, bubble_EXMEM;
  logic        flush_IFID, flush_IDEX, flush_EXMEM, mc_busy;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] stall_cnt, flush_cnt;

  logic        PCWrite2, Write_IFID2, control_mux_sel2, hold_IDEX2, bubble_EXMEM2;
  logic        flush_IFID2, flush_IDEX2, flush_EXMEM2, mc_busy2;
  logic [1:0]  ForwardA2, ForwardB2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl_unit u_dut (
    .clk(clk), .rst(rst), .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
    .memRead_IDEX(memRead_IDEX), .mc_op_IDEX(mc_op_IDEX),
    .rd_EXMEM(rd_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
    .rd_MEMWB(rd_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .branch_taken(branch_taken), .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .control_mux_sel(control_mux_sel), .hold_IDEX(hold_IDEX),
    .bubble_EXMEM(bubble_EXMEM), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .flush_EXMEM(flush_EXMEM), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl_unit #(.REG_AW(5), .MC_LAT(2), .FLUSH_STAGES(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
    .memRead_IDEX(memRead_IDEX), .mc_op_IDEX(mc_op_IDEX),
    .rd_EXMEM(rd_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
    .rd_MEMWB(rd_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .branch_taken(branch_taken), .PCWrite(PCWrite2), .Write_IFID(Write_IFID2),
    .control_mux_sel(control_mux_sel2), .hold_IDEX(hold_IDEX2),
    .bubble_EXMEM(bubble_EXMEM2), .flush_IFID(flush_IFID2), .flush_IDEX(flush_IDEX2),
    .flush_EXMEM(flush_EXMEM2), .ForwardA(ForwardA2), .ForwardB(ForwardB2),
    .mc_busy(mc_busy2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs;
    rs1_IFID = 0; rs2_IFID = 0; rs1_IDEX = 0; rs2_IDEX = 0; rd_IDEX = 0;
    rd_EXMEM = 0; rd_MEMWB = 0; memRead_IDEX = 0; mc_op_IDEX = 0;
    RegWrite_EXMEM = 0; RegWrite_MEMWB = 0; branch_taken = 0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    memRead_IDEX = 1; rd_IDEX = 5; rs1_IFID = 5; branch_taken = 1; mc_op_IDEX = 1;
    RegWrite_EXMEM = 1; rd_EXMEM = 3; rs1_IDEX = 3;
    @(negedge clk);
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL rst_pcwrite got=%0b exp=1", PCWrite); end
    n_checks++; if (Write_IFID !== 1'b1) begin n_fail++; $display("FAIL rst_write_ifid got=%0b exp=1", Write_IFID); end
    n_checks++; if (control_mux_sel !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl_mux got=%0b exp=0", control_mux_sel); end
    n_checks++; if (flush_IFID !== 1'b0) begin n_fail++; $display("FAIL rst_flush_ifid got=%0b exp=0", flush_IFID); end
    n_checks++; if (hold_IDEX !== 1'b0) begin n_fail++; $display("FAIL rst_hold got=%0b exp=0", hold_IDEX); end
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL rst_fwda got=%0b exp=00", ForwardA); end
    step();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    n_checks++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_flush_cnt got=%0d exp=0", flush_cnt); end
    n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mc_busy got=%0b exp=0", mc_busy); end
  endtask

  task automatic test_load_use;
    do_reset();
    memRead_IDEX = 1; rd_IDEX = 5; rs2_IFID = 5; rs1_IFID = 2;
    @(negedge clk);
    n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL lu_pcwrite got=%0b exp=0", PCWrite); end
    n_checks++; if (Write_IFID !== 1'b0) begin n_fail++; $display("FAIL lu_write_ifid got=%0b exp=0", Write_IFID); end
    n_checks++; if (control_mux_sel !== 1'b1) begin n_fail++; $display("FAIL lu_ctrl_mux got=%0b exp=1", control_mux_sel); end
    n_checks++; if (hold_IDEX !== 1'b0) begin n_fail++; $display("FAIL lu_hold got=%0b exp=0", hold_IDEX); end
    step();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL lu_release got=%0b exp=1", PCWrite); end
    step();
    memRead_IDEX = 1; rd_IDEX = 0; rs1_IFID = 0; rs2_IFID = 0;
    @(negedge clk);
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL lu_rd0_pcwrite got=%0b exp=1", PCWrite); end
    n_checks++; if (control_mux_sel !== 1'b0) begin n_fail++; $display("FAIL lu_rd0_ctrl_mux got=%0b exp=0", control_mux_sel); end
    step();
    rd_IDEX = 9; rs1_IFID = 9; rs2_IFID = 1;
    @(negedge clk);
    n_checks++; if (control_mux_sel !== 1'b1) begin n_fail++; $display("FAIL lu_rs1_ctrl_mux got=%0b exp=1", control_mux_sel); end
    step();
    memRead_IDEX = 0;
    @(negedge clk);
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL lu_noload_pcwrite got=%0b exp=1", PCWrite); end
    n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_mc_op;
    logic [4:0] exp_pc;
    logic [4:0] exp_busy;
    exp_pc   = 5'b11000;
    exp_busy = 5'b01110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mc_op_IDEX = (i < 4);
      @(negedge clk);
      n_checks++; if (PCWrite !== exp_pc[i]) begin n_fail++; $display("FAIL mc4_pcwrite[%0d] got=%0b exp=%0b", i, PCWrite, exp_pc[i]); end
      n_checks++; if (mc_busy !== exp_busy[i]) begin n_fail++; $display("FAIL mc4_busy[%0d] got=%0b exp=%0b", i, mc_busy, exp_busy[i]); end
      n_checks++; if (hold_IDEX !== !exp_pc[i]) begin n_fail++; $display("FAIL mc4_hold[%0d] got=%0b exp=%0b", i, hold_IDEX, !exp_pc[i]); end
      n_checks++; if (bubble_EXMEM !== !exp_pc[i]) begin n_fail++; $display("FAIL mc4_bubble[%0d] got=%0b exp=%0b", i, bubble_EXMEM, !exp_pc[i]); end
      step();
    end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL mc4_stall_cnt got=%0d exp=3", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_mc_lat2;
    logic [2:0] exp_pc;
    logic [2:0] exp_busy;
    exp_pc   = 3'b110;
    exp_busy = 3'b010;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mc_op_IDEX = (i < 2);
      @(negedge clk);
      n_checks++; if (PCWrite2 !== exp_pc[i]) begin n_fail++; $display("FAIL mc2_pcwrite[%0d] got=%0b exp=%0b", i, PCWrite2, exp_pc[i]); end
      n_checks++; if (mc_busy2 !== exp_busy[i]) begin n_fail++; $display("FAIL mc2_busy[%0d] got=%0b exp=%0b", i, mc_busy2, exp_busy[i]); end
      step();
    end
    n_checks++; if (stall_cnt2 !== 4'd1) begin n_fail++; $display("FAIL mc2_stall_cnt got=%0d exp=1", stall_cnt2); end
    clear_inputs();
  endtask

  task automatic test_branch_mc;
    do_reset();
    mc_op_IDEX = 1;
    step();
    branch_taken = 1;
    @(negedge clk);
    n_checks++; if (flush_IFID !== 1'b1) begin n_fail++; $display("FAIL bmc_flush_ifid got=%0b exp=1", flush_IFID); end
    n_checks++; if (flush_IDEX !== 1'b1) begin n_fail++; $display("FAIL bmc_flush_idex got=%0b exp=1", flush_IDEX); end
    n_checks++; if (flush_EXMEM !== 1'b0) begin n_fail++; $display("FAIL bmc_flush_exmem got=%0b exp=0", flush_EXMEM); end
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL bmc_pcwrite got=%0b exp=1", PCWrite); end
    n_checks++; if (hold_IDEX !== 1'b0) begin n_fail++; $display("FAIL bmc_hold got=%0b exp=0", hold_IDEX); end
    n_checks++; if (mc_busy !== 1'b1) begin n_fail++; $display("FAIL bmc_busy_before got=%0b exp=1", mc_busy); end
    step();
    branch_taken = 0; mc_op_IDEX = 0;
    @(negedge clk);
    n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL bmc_busy_after got=%0b exp=0", mc_busy); end
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL bmc_pcwrite_after got=%0b exp=1", PCWrite); end
    n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL bmc_flush_cnt got=%0d exp=1", flush_cnt); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL bmc_stall_cnt got=%0d exp=1", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_simultaneous;
    do_reset();
    branch_taken = 1; memRead_IDEX = 1; rd_IDEX = 5; rs1_IFID = 5;
    @(negedge clk);
    n_checks++; if (control_mux_sel !== 1'b0) begin n_fail++; $display("FAIL sim_ctrl_mux got=%0b exp=0", control_mux_sel); end
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL sim_pcwrite got=%0b exp=1", PCWrite); end
    n_checks++; if (Write_IFID !== 1'b1) begin n_fail++; $display("FAIL sim_write_ifid got=%0b exp=1", Write_IFID); end
    n_checks++; if (flush_IDEX !== 1'b1) begin n_fail++; $display("FAIL sim_flush_idex got=%0b exp=1", flush_IDEX); end
    n_checks++; if (flush_EXMEM !== 1'b0) begin n_fail++; $display("FAIL sim_flush_exmem2 got=%0b exp=0", flush_EXMEM); end
    n_checks++; if (flush_EXMEM2 !== 1'b1) begin n_fail++; $display("FAIL sim_flush_exmem3 got=%0b exp=1", flush_EXMEM2); end
    step();
    memRead_IDEX = 0; mc_op_IDEX = 1;
    @(negedge clk);
    n_checks++; if (hold_IDEX !== 1'b0) begin n_fail++; $display("FAIL sim_mc_hold got=%0b exp=0", hold_IDEX); end
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL sim_mc_pcwrite got=%0b exp=1", PCWrite); end
    step();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL sim_mc_busy got=%0b exp=0", mc_busy); end
    n_checks++; if (flush_cnt !== 16'd2) begin n_fail++; $display("FAIL sim_flush_cnt got=%0d exp=2", flush_cnt); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL sim_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    rd_EXMEM = 7; rd_MEMWB = 7; RegWrite_EXMEM = 1; RegWrite_MEMWB = 1; rs1_IDEX = 7; rs2_IDEX = 7;
    @(negedge clk);
    n_checks++; if (ForwardA !== 2'b10) begin n_fail++; $display("FAIL fwd_both_a got=%0b exp=10", ForwardA); end
    n_checks++; if (ForwardB !== 2'b10) begin n_fail++; $display("FAIL fwd_both_b got=%0b exp=10", ForwardB); end
    RegWrite_EXMEM = 0;
    @(negedge clk);
    n_checks++; if (ForwardA !== 2'b01) begin n_fail++; $display("FAIL fwd_memwb_a got=%0b exp=01", ForwardA); end
    rd_EXMEM = 0; rd_MEMWB = 0; RegWrite_EXMEM = 1; rs1_IDEX = 0; rs2_IDEX = 0;
    @(negedge clk);
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL fwd_rd0_a got=%0b exp=00", ForwardA); end
    n_checks++; if (ForwardB !== 2'b00) begin n_fail++; $display("FAIL fwd_rd0_b got=%0b exp=00", ForwardB); end
    rd_EXMEM = 3; rd_MEMWB = 7; rs1_IDEX = 7; rs2_IDEX = 3;
    @(negedge clk);
    n_checks++; if (ForwardA !== 2'b01) begin n_fail++; $display("FAIL fwd_split_a got=%0b exp=01", ForwardA); end
    n_checks++; if (ForwardB !== 2'b10) begin n_fail++; $display("FAIL fwd_split_b got=%0b exp=10", ForwardB); end
    RegWrite_MEMWB = 0;
    @(negedge clk);
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL fwd_nowr_a got=%0b exp=00", ForwardA); end
    clear_inputs();
  endtask

  task automatic test_saturation_reset;
    do_reset();
    memRead_IDEX = 1; rd_IDEX = 3; rs1_IFID = 3;
    repeat (20) @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    n_checks++; if (stall_cnt2 !== 4'd15) begin n_fail++; $display("FAIL sat_stall_cnt4 got=%0d exp=15", stall_cnt2); end
    n_checks++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_stall_cnt16 got=%0d exp=20", stall_cnt); end
    branch_taken = 1;
    repeat (20) @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    n_checks++; if (flush_cnt2 !== 4'd15) begin n_fail++; $display("FAIL sat_flush_cnt4 got=%0d exp=15", flush_cnt2); end
    n_checks++; if (flush_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_flush_cnt16 got=%0d exp=20", flush_cnt); end
    step();
    mc_op_IDEX = 1;
    step();
    @(negedge clk);
    n_checks++; if (mc_busy !== 1'b1) begin n_fail++; $display("FAIL rstmc_busy got=%0b exp=1", mc_busy); end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL rstmc_pcwrite_in_rst got=%0b exp=1", PCWrite); end
    n_checks++; if (bubble_EXMEM !== 1'b0) begin n_fail++; $display("FAIL rstmc_bubble_in_rst got=%0b exp=0", bubble_EXMEM); end
    step();
    rst = 1'b0;
    mc_op_IDEX = 0;
    @(negedge clk);
    n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL rstmc_busy_after got=%0b exp=0", mc_busy); end
    n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL rstmc_pcwrite got=%0b exp=1", PCWrite); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmc_stall_cnt got=%0d exp=0", stall_cnt); end
    n_checks++; if (flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmc_flush_cnt got=%0d exp=0", flush_cnt); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_mc_op();
    test_mc_lat2();
    test_branch_mc();
    test_simultaneous();
    test_forwarding();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
